handshaking_rx_buffer: RTL and testbench
========================================

Name: handshaking_rx_buffer

Overview:
Receiving end of the team's valid/ready byte handshake. It accepts words from a handshaking master (valid_in/data_in, answering with ready_out) and buffers them in a small first-word-fall-through FIFO. It re-presents the words to a downstream consumer over a second valid/ready pair. It also checks upstream protocol compliance and counts accepted words, replacing the fixed-behaviour slave wherever back-pressure and buffering are needed.

Parameters:
DATA_WIDTH, 8, width of data_in/data_out
DEPTH, 4, FIFO entries; power of two, minimum 2
CNT_WIDTH, 16, width of the accepted-word counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
valid_in  input  1  upstream word valid
data_in  input  DATA_WIDTH  upstream word
ready_out  output  1  buffer can accept a word this cycle
valid_out  output  1  downstream word available
data_out  output  DATA_WIDTH  head-of-FIFO word
ready_in  input  1  downstream consumer accepts the word this cycle
level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
accept_count  output  CNT_WIDTH  number of accepted upstream words, wraps modulo 2^CNT_WIDTH
proto_err  output  1  sticky flag for an upstream protocol violation

Behaviour:
- Reset (rst=0 at clk edge):
  - wr_ptr, rd_ptr, level, accept_count and proto_err clear to 0.
  - valid_out=0 and ready_out=1 from the following cycle.
  - FIFO storage is not cleared; data_out is don't-care while valid_out=0.
  - Reset mid-transfer discards all buffered words.
- push = valid_in & ready_out. pop = valid_out & ready_in.
- ready_out = (level != DEPTH). valid_out = (level != 0). Both are combinational from registered level only, with no path from valid_in or ready_in.
- data_out = mem[rd_ptr]: first-word fall-through, no extra read latency.
- Latency: a word pushed at edge N is visible on valid_out/data_out after edge N (cycle N+1). Minimum accept-to-present latency is 1 cycle.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Level update:
  - push only: level+1.
  - pop only: level-1.
  - both: unchanged. A simultaneous push and pop is legal at any level 1..DEPTH-1.
- Full (level=DEPTH):
  - ready_out=0, so no push occurs even if a pop happens that cycle. Full throughput at full occupancy is deliberately not supported.
  - ready_out returns to 1 the cycle after a pop.
- Empty (level=0): valid_out=0, so no pop. A push that cycle makes valid_out=1 next cycle; there is no bypass.
- accept_count increments by 1 on every push and wraps from 2^CNT_WIDTH-1 to 0.
- Protocol monitor: sets proto_err=1 in either of these cases, which the buffer still tolerates:
  - valid_in drops while a word was offered the previous cycle but not taken. The monitor registers offered_q = valid_in & ~ready_out and data_q.
  - data_in changes while offered_q=1 and valid_in=1.
  - proto_err stays set until reset.
- Downstream obligations are the consumer's responsibility and are not checked. The buffer itself never drops valid_out or changes data_out while valid_out=1 and ready_in=0.

Decomposition:
- Shared package handshaking_pkg holds:
  - default DATA_WIDTH and DEPTH constants;
  - a function computing pointer width from DEPTH.
- Shared with handshaking_master and handshaking_slave.
- One natural sub-module, handshaking_proto_monitor, holding the offered_q/data_q registers and the proto_err flag. It is reusable on any valid/ready link.
- FIFO storage and pointer logic stay in the top module.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then 1 -> valid_out=0, ready_out=1, level=0, accept_count=0, proto_err=0.
- Fill, no drain: DEPTH=4, ready_in=0, push 0xA1,0xA2,0xA3,0xA4 on consecutive cycles -> level 1,2,3,4; ready_out=0 after the 4th push; a 5th offer 0xA5 is held with no push and accept_count=4.
- Drain in order: from the full state, ready_in=1 for 4 cycles -> data_out reads 0xA1..0xA4 in order; valid_out=0 after the 4th pop; ready_out=1 after the first pop.
- Streaming: valid_in=1 and ready_in=1 continuously for 10 words 0x00..0x09 -> level stays 1 after the first word; output equals input delayed 1 cycle; accept_count=10.
- Wrap and counter: with CNT_WIDTH=4, push/pop 20 words -> pointers wrap with no data corruption; accept_count=4.
- Protocol error: offer 0x55 while full, then change data_in to 0x66 with valid_in still 1 -> proto_err=1 next cycle; it stays 1 through later traffic and clears only on rst=0.

Source files
------------

// File: rtl/handshaking_pkg.sv
// Shared definitions for the valid/ready handshake family (master, slave, rx buffer).
package handshaking_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_DEPTH      = 4;

   // Pointer width for a FIFO of the given depth; never narrower than one bit.
   function automatic int ptrWidth(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/handshaking_proto_monitor.sv
// Upstream protocol checker for a valid/ready link: once a word has been offered
// and not taken, valid must stay high and data must stay stable until it is taken.
module handshaking_proto_monitor #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_valid,
   input  logic                  i_ready,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_protoErr
);

   logic                  r_offered;
   logic [DATA_WIDTH-1:0] r_dataQ;
   logic                  r_protoErr;
   logic                  w_violation;

   // A pending offer that is withdrawn or altered counts as a violation.
   always_comb begin
      w_violation = 1'b0;
      if (r_offered && (!i_valid || (i_data != r_dataQ))) begin
         w_violation = 1'b1;
      end
   end

   // Remember last cycle's unaccepted offer and hold the error flag until reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_offered  <= 1'b0;
         r_dataQ    <= '0;
         r_protoErr <= 1'b0;
      end else begin
         r_offered  <= i_valid & ~i_ready;
         r_dataQ    <= i_data;
         r_protoErr <= r_protoErr | w_violation;
      end
   end

   assign o_protoErr = r_protoErr;

endmodule

// File: rtl/handshaking_rx_buffer.sv
// Receive side of the valid/ready byte handshake: a first-word-fall-through FIFO
// that decouples the upstream master from a downstream consumer, counts accepted
// words and flags upstream protocol violations.
module handshaking_rx_buffer
   import handshaking_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DEPTH      = DEFAULT_DEPTH,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   valid_in,
   input  logic [DATA_WIDTH-1:0]  data_in,
   output logic                   ready_out,
   output logic                   valid_out,
   output logic [DATA_WIDTH-1:0]  data_out,
   input  logic                   ready_in,
   output logic [$clog2(DEPTH):0] level,
   output logic [CNT_WIDTH-1:0]   accept_count,
   output logic                   proto_err
);

   localparam int               PTR_W      = ptrWidth(DEPTH);
   localparam int               LVL_W      = $clog2(DEPTH) + 1;
   localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]      r_wrPtr;
   logic [PTR_W-1:0]      r_rdPtr;
   logic [LVL_W-1:0]      r_level;
   logic [CNT_WIDTH-1:0]  r_acceptCount;
   logic                  w_ready;
   logic                  w_valid;
   logic                  w_push;
   logic                  w_pop;

   // Handshake status depends only on the registered level, so neither valid_in
   // nor ready_in has a combinational path to the opposite side.
   assign w_ready = (r_level != FULL_LEVEL);
   assign w_valid = (r_level != '0);
   assign w_push  = valid_in & w_ready;
   assign w_pop   = w_valid & ready_in;

   // Storage has no reset; stale entries are never visible while valid_out is low.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= data_in;
      end
   end

   // Pointers, occupancy and accepted-word counter; reset discards buffered words.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wrPtr       <= '0;
         r_rdPtr       <= '0;
         r_level       <= '0;
         r_acceptCount <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr       <= r_wrPtr + PTR_W'(1);
            r_acceptCount <= r_acceptCount + CNT_WIDTH'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   handshaking_proto_monitor #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_protoMonitor (
      .clk        (clk),
      .rst        (rst),
      .i_valid    (valid_in),
      .i_ready    (w_ready),
      .i_data     (data_in),
      .o_protoErr (proto_err)
   );

   assign ready_out    = w_ready;
   assign valid_out    = w_valid;
   assign data_out     = r_mem[r_rdPtr];
   assign level        = r_level;
   assign accept_count = r_acceptCount;

endmodule

// File: tb/tb_handshaking_rx_buffer.sv
// Self-checking bench for handshaking_rx_buffer: table-driven fill/drain vectors,
// a reference model with a data scoreboard queue, and hand-written corner sequences.
module tb_handshaking_rx_buffer;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int CW    = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          valid_in;
   logic [DW-1:0] data_in;
   logic          ready_out;
   logic          valid_out;
   logic [DW-1:0] data_out;
   logic          ready_in;
   logic [2:0]    level;
   logic [CW-1:0] accept_count;
   logic          proto_err;

   int nChecks = 0;
   int nFails  = 0;

   int            mLevel;
   int            mCount;
   logic          mOffered;
   logic [DW-1:0] mDataQ;
   logic          mErr;
   logic [DW-1:0] mq[$];

   typedef struct {
      logic          vin;
      logic [DW-1:0] din;
      logic          rin;
      int            expLevel;
      logic          expReady;
      logic          expValid;
      int            expCount;
      logic          expErr;
   } vec_t;

   vec_t fillDrain[10];

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   handshaking_rx_buffer #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .valid_in     (valid_in),
      .data_in      (data_in),
      .ready_out    (ready_out),
      .valid_out    (valid_out),
      .data_out     (data_out),
      .ready_in     (ready_in),
      .level        (level),
      .accept_count (accept_count),
      .proto_err    (proto_err)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkVal(input string name, input int act, input int exp);
      nChecks++;
      if (act != exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic modelReset();
      mLevel   = 0;
      mCount   = 0;
      mOffered = 1'b0;
      mDataQ   = '0;
      mErr     = 1'b0;
      mq.delete();
   endtask

   // Compare every observable output against the reference model.
   task automatic checkOutput(input string tag);
      checkVal({tag, ".level"},     int'(level),        mLevel);
      checkVal({tag, ".ready_out"}, int'(ready_out),    int'(mLevel != DEPTH));
      checkVal({tag, ".valid_out"}, int'(valid_out),    int'(mLevel != 0));
      checkVal({tag, ".count"},     int'(accept_count), mCount);
      checkVal({tag, ".proto_err"}, int'(proto_err),    int'(mErr));
      if (mq.size() > 0) begin
         checkVal({tag, ".head"}, int'(data_out), int'(mq[0]));
      end
   endtask

   // Drive one cycle of inputs, advance the model and scoreboard, then clock.
   task automatic applyStimulus(input logic vin, input logic [DW-1:0] din, input logic rin);
      logic mReady;
      logic mValid;
      logic mPush;
      logic mPop;
      valid_in = vin;
      data_in  = din;
      ready_in = rin;
      mReady   = (mLevel != DEPTH);
      mValid   = (mLevel != 0);
      mPush    = vin && mReady;
      mPop     = mValid && rin;
      if (mPop && mq.size() > 0) begin
         checkVal("scoreboard.data_out", int'(data_out), int'(mq.pop_front()));
      end
      if (mOffered && (!vin || din != mDataQ)) begin
         mErr = 1'b1;
      end
      mOffered = vin && !mReady;
      mDataQ   = din;
      if (mPush) begin
         mq.push_back(din);
         mCount = (mCount + 1) % (1 << CW);
      end
      if (mPush && !mPop) mLevel++;
      if (!mPush && mPop) mLevel--;
      @(posedge clk);
      #1;
   endtask

   task automatic applyReset(input string tag);
      rst      = 1'b0;
      valid_in = 1'b0;
      ready_in = 1'b0;
      data_in  = '0;
      repeat (2) @(posedge clk);
      #1;
      modelReset();
      checkOutput(tag);
      rst = 1'b1;
   endtask

   // Hard stop in case something blocks the main sequence.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int   accepted;
      int   cyc;
      logic willPush;
      logic [DW-1:0] curData;

      fillDrain[0] = '{1'b1, 8'hA1, 1'b0, 1, 1'b1, 1'b1, 1, 1'b0};
      fillDrain[1] = '{1'b1, 8'hA2, 1'b0, 2, 1'b1, 1'b1, 2, 1'b0};
      fillDrain[2] = '{1'b1, 8'hA3, 1'b0, 3, 1'b1, 1'b1, 3, 1'b0};
      fillDrain[3] = '{1'b1, 8'hA4, 1'b0, 4, 1'b0, 1'b1, 4, 1'b0};
      fillDrain[4] = '{1'b1, 8'hA5, 1'b0, 4, 1'b0, 1'b1, 4, 1'b0};
      fillDrain[5] = '{1'b1, 8'hA5, 1'b1, 3, 1'b1, 1'b1, 4, 1'b0};
      fillDrain[6] = '{1'b1, 8'hA5, 1'b1, 3, 1'b1, 1'b1, 5, 1'b0};
      fillDrain[7] = '{1'b0, 8'h00, 1'b1, 2, 1'b1, 1'b1, 5, 1'b0};
      fillDrain[8] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 1'b1, 5, 1'b0};
      fillDrain[9] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 5, 1'b0};

      $display("[TB] reset and idle");
      modelReset();
      applyReset("reset");
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("idle");

      $display("[TB] fill, held offer, drain in order");
      for (int i = 0; i < 10; i++) begin
         applyStimulus(fillDrain[i].vin, fillDrain[i].din, fillDrain[i].rin);
         checkVal($sformatf("vec%0d.level", i),     int'(level),        fillDrain[i].expLevel);
         checkVal($sformatf("vec%0d.ready_out", i), int'(ready_out),    int'(fillDrain[i].expReady));
         checkVal($sformatf("vec%0d.valid_out", i), int'(valid_out),    int'(fillDrain[i].expValid));
         checkVal($sformatf("vec%0d.count", i),     int'(accept_count), fillDrain[i].expCount);
         checkVal($sformatf("vec%0d.proto_err", i), int'(proto_err),    int'(fillDrain[i].expErr));
      end

      $display("[TB] streaming ten words");
      applyReset("stream.reset");
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 8'(i), 1'b1);
         checkVal($sformatf("stream%0d.level", i), int'(level), 1);
      end
      checkVal("stream.count", int'(accept_count), 10);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("stream.end");

      $display("[TB] pointer and counter wrap");
      applyReset("wrap.reset");
      accepted = 0;
      cyc      = 0;
      curData  = 8'($urandom);
      while (accepted < 20 && cyc < 400) begin
         willPush = (mLevel != DEPTH);
         applyStimulus(1'b1, curData, 1'($urandom_range(0, 1)));
         if (willPush) begin
            accepted++;
            curData = 8'($urandom);
         end
         cyc++;
      end
      checkVal("wrap.accepted", accepted, 20);
      cyc = 0;
      while (mLevel > 0 && cyc < 20) begin
         applyStimulus(1'b0, 8'h00, 1'b1);
         cyc++;
      end
      checkOutput("wrap.end");
      checkVal("wrap.count", int'(accept_count), 4);

      $display("[TB] protocol violation");
      applyReset("proto.reset");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 8'hB0 + 8'(i), 1'b0);
      end
      applyStimulus(1'b1, 8'h55, 1'b0);
      checkVal("proto.legalOffer", int'(proto_err), 0);
      applyStimulus(1'b1, 8'h66, 1'b0);
      checkVal("proto.set", int'(proto_err), 1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1);
      end
      applyStimulus(1'b1, 8'h77, 1'b1);
      applyStimulus(1'b1, 8'h78, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("proto.sticky");
      checkVal("proto.stillSet", int'(proto_err), 1);
      applyReset("proto.cleared");
      checkVal("proto.clear", int'(proto_err), 0);

      $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
      $finish;
   end

endmodule
